fpga_cfg_loader: RTL and testbench

//  Configuration sequencer for the fabric's configuration chain. Accepts bitstream bytes over a

---
 rtl/fpga_cfg_pkg.sv | 27 ++
 rtl/fpga_cfg_clkgen.sv | 42 ++++
 rtl/fpga_cfg_loader.sv | 236 +++++++++++++++++++++++
 tb/tb_fpga_cfg_loader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// -----------------------------------------------------------------------------
// fpga_cfg_pkg
// Shared definitions for the configuration-chain loader:
//   - state_t        : sequencer states
//   - DEF_CHAIN_LEN  : default number of flops in the configuration chain
//   - DEF_PROG_DIV   : default clk cycles per prog_clk half-period
//   - phase_w()      : width of a counter that spans 0..div-1 (never below 1)
// -----------------------------------------------------------------------------
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHLO  = 3'd2,
        SHHI  = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam int DEF_CHAIN_LEN = 2048;
    localparam int DEF_PROG_DIV  = 4;

    // A divider of 1 still needs a 1-bit counter so the port/regs stay legal.
    function automatic int phase_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/fpga_cfg_clkgen.sv
// -----------------------------------------------------------------------------
// fpga_cfg_clkgen
// Phase timer for one half-period of prog_clk. While enabled it counts
// 0..PROG_DIV-1 and pulses o_phase_end on the final count, then wraps to 0 so
// the next half-period starts cleanly. When disabled the counter is held at 0,
// so every enabled stretch begins with a full PROG_DIV-cycle phase.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   i_en         in   count enable (high while a bit is being shifted)
//   o_phase_end  out  high on the last clk cycle of the current half-period
// -----------------------------------------------------------------------------
module fpga_cfg_clkgen
    import fpga_cfg_pkg::*;
#(
    parameter int PROG_DIV = DEF_PROG_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_phase_end
);

    localparam int              PH_W    = phase_w(PROG_DIV);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PROG_DIV - 1);

    logic [PH_W-1:0] r_phase;

    assign o_phase_end = i_en && (r_phase == PH_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
        end else if (!i_en || o_phase_end) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

endmodule

// File: rtl/fpga_cfg_loader.sv
// -----------------------------------------------------------------------------
// fpga_cfg_loader
// Configuration sequencer for the fabric's configuration chain. Bitstream bytes
// arrive over a valid/ready handshake and are shifted MSB-first onto
// o_ccff_head, one bit per prog_clk period (PROG_DIV clk low, PROG_DIV clk
// high). The fabric is held in reset (o_fpga_rst) for the whole pass. A verify
// pass re-shifts the same bitstream and compares i_ccff_tail with the bit being
// driven; any mismatch sets a sticky error that keeps the fabric in reset.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   i_start       in   1-cycle pulse: begin a pass (ignored unless idle)
//   i_verify      in   sampled with i_start: 0 = load pass, 1 = verify pass
//   i_byte_data   in   bitstream byte, MSB shifted first
//   i_byte_valid  in   i_byte_data valid
//   o_byte_ready  out  byte accepted this cycle when i_byte_valid is high
//   o_prog_clk    out  configuration shift clock to the fabric
//   o_ccff_head   out  serial configuration data into the chain
//   i_ccff_tail   in   serial configuration data out of the chain
//   o_fpga_rst    out  active-high fabric reset
//   o_busy        out  pass in progress
//   o_done        out  1-cycle pulse at the end of a pass
//   o_error       out  sticky verify mismatch, cleared by the next start
//   o_bit_cnt     out  bits shifted in the current pass (saturates at CHAIN_LEN)
// -----------------------------------------------------------------------------
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int PROG_DIV  = DEF_PROG_DIV,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_verify,
    input  logic [7:0]       i_byte_data,
    input  logic             i_byte_valid,
    output logic             o_byte_ready,
    output logic             o_prog_clk,
    output logic             o_ccff_head,
    input  logic             i_ccff_tail,
    output logic             o_fpga_rst,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [CNT_W-1:0] o_bit_cnt
);

    // Leaving SHHI with this count means the chain is now full.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    state_t           r_state;
    state_t           w_state_next;

    logic [7:0]       r_shreg;
    logic [2:0]       r_bit_idx;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_verify;
    logic             r_error;
    logic             r_fpga_rst;

    // Outputs decoded from the next state and registered, so the fabric-facing
    // strobes come straight from flops and never glitch.
    logic             r_prog_clk;
    logic             r_busy;
    logic             r_done;
    logic             r_ready;

    logic             w_phase_en;
    logic             w_phase_end;
    logic             w_accept;
    logic             w_start;
    logic             w_bit_last;
    logic             w_byte_last;
    logic             w_shift_exit;
    logic             w_sample;

    // -------------------------------------------------------------------------
    // Half-period timer
    // -------------------------------------------------------------------------
    assign w_phase_en = (r_state == SHLO) || (r_state == SHHI);

    fpga_cfg_clkgen #(
        .PROG_DIV (PROG_DIV)
    ) u_clkgen (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (w_phase_en),
        .o_phase_end (w_phase_end)
    );

    // -------------------------------------------------------------------------
    // Control decodes
    // -------------------------------------------------------------------------
    assign w_start      = (r_state == IDLE) && i_start;
    assign w_accept     = r_ready && i_byte_valid;
    assign w_bit_last   = (r_bit_cnt == CNT_LAST);
    assign w_byte_last  = (r_bit_idx == 3'd0);
    // End of the high phase: the chain has taken the bit, move to the next one.
    assign w_shift_exit = (r_state == SHHI) && w_phase_end;
    // Last low-phase cycle: the chain output is settled and about to be shifted,
    // so this is where it lines up with the bit currently on the head.
    assign w_sample     = (r_state == SHLO) && w_phase_end;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                if (w_accept) begin
                    w_state_next = SHLO;
                end
            end
            SHLO: begin
                if (w_phase_end) begin
                    w_state_next = SHHI;
                end
            end
            SHHI: begin
                if (w_phase_end) begin
                    // Chain-full check comes first: when CHAIN_LEN is not a
                    // multiple of 8 the unused low bits of the last byte are
                    // simply dropped here.
                    if (w_bit_last) begin
                        w_state_next = FIN;
                    end else if (w_byte_last) begin
                        w_state_next = FETCH;
                    end else begin
                        w_state_next = SHLO;
                    end
                end
            end
            FIN: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered strobes
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prog_clk <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_prog_clk <= (w_state_next == SHHI);
            r_busy     <= (w_state_next == FETCH) ||
                          (w_state_next == SHLO)  ||
                          (w_state_next == SHHI);
            r_done     <= (w_state_next == FIN);
            r_ready    <= (w_state_next == FETCH);
        end
    end

    // -------------------------------------------------------------------------
    // Shift register, bit counters, verify compare, fabric reset
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg    <= 8'h00;
            r_bit_idx  <= 3'd0;
            r_bit_cnt  <= '0;
            r_verify   <= 1'b0;
            r_error    <= 1'b0;
            r_fpga_rst <= 1'b1;
        end else begin
            if (w_start) begin
                r_verify   <= i_verify;
                r_error    <= 1'b0;
                r_bit_cnt  <= '0;
                r_fpga_rst <= 1'b1;
            end

            if (w_accept) begin
                r_shreg   <= i_byte_data;
                r_bit_idx <= 3'd7;
            end

            if (w_sample && r_verify && (i_ccff_tail != r_shreg[7])) begin
                r_error <= 1'b1;
            end

            // The shift happens as prog_clk falls, so the head only ever
            // changes while prog_clk is low.
            if (w_shift_exit) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_shreg   <= {r_shreg[6:0], 1'b0};
                r_bit_idx <= r_bit_idx - 3'd1;
                // Release the fabric together with the done pulse, but only if
                // the pass was clean; otherwise it stays held in reset.
                if (w_bit_last) begin
                    r_fpga_rst <= r_error;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_byte_ready = r_ready;
    assign o_prog_clk   = r_prog_clk;
    assign o_ccff_head  = r_shreg[7];
    assign o_fpga_rst   = r_fpga_rst;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_bit_cnt    = r_bit_cnt;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_fpga_cfg_loader
// Two loader instances share clock, reset and byte stream: u_dut16 (16-flop
// chain, PROG_DIV=2) and u_dut12 (12-flop chain, PROG_DIV=1). Only one is
// started at a time; the idle one never raises byte_ready so it ignores the
// shared byte stream. Each has a behavioural chain model on its prog_clk.
// Expected head bits are queued when bytes are offered and popped on each
// prog_clk rising edge.
// -----------------------------------------------------------------------------
module tb_fpga_cfg_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start16 = 1'b0;
    logic       start12 = 1'b0;
    logic       verify_in = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;

    logic       ready16, pc16, head16, frst16, busy16, done16, err16;
    logic [4:0] cnt16;
    logic       ready12, pc12, head12, frst12, busy12, done12, err12;
    logic [3:0] cnt12;

    logic [15:0] chain16 = '0;
    logic [11:0] chain12 = '0;
    logic        tail16, tail12;

    always #5 clk = ~clk;

    fpga_cfg_loader #(.CHAIN_LEN(16), .PROG_DIV(2)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .i_start(start16), .i_verify(verify_in),
        .i_byte_data(byte_data), .i_byte_valid(byte_valid), .o_byte_ready(ready16),
        .o_prog_clk(pc16), .o_ccff_head(head16), .i_ccff_tail(tail16),
        .o_fpga_rst(frst16), .o_busy(busy16), .o_done(done16), .o_error(err16),
        .o_bit_cnt(cnt16)
    );

    fpga_cfg_loader #(.CHAIN_LEN(12), .PROG_DIV(1)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .i_start(start12), .i_verify(verify_in),
        .i_byte_data(byte_data), .i_byte_valid(byte_valid), .o_byte_ready(ready12),
        .o_prog_clk(pc12), .o_ccff_head(head12), .i_ccff_tail(tail12),
        .o_fpga_rst(frst12), .o_busy(busy12), .o_done(done12), .o_error(err12),
        .o_bit_cnt(cnt12)
    );

    // Configuration chain models: shift on the rising edge of prog_clk.
    always @(posedge pc16) chain16 <= {chain16[14:0], head16};
    always @(posedge pc12) chain12 <= {chain12[10:0], head12};
    assign tail16 = chain16[15];
    assign tail12 = chain12[11];

    // View of whichever instance is under test.
    logic       sel = 1'b0;
    logic       w_pc, w_head, w_ready, w_frst, w_busy, w_done, w_err;
    logic [4:0] w_cnt;
    assign w_pc    = sel ? pc12    : pc16;
    assign w_head  = sel ? head12  : head16;
    assign w_ready = sel ? ready12 : ready16;
    assign w_frst  = sel ? frst12  : frst16;
    assign w_busy  = sel ? busy12  : busy16;
    assign w_done  = sel ? done12  : done16;
    assign w_err   = sel ? err12   : err16;
    assign w_cnt   = sel ? {1'b0, cnt12} : cnt16;

    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_q[$];
    int   pushed = 0;
    int   edges = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Samples on the falling clk edge, away from the active edge.
    task automatic monitor();
        logic prev_pc, prev_head, e_bit;
        int   hi_len, cyc, last_rise, pd;
        prev_pc = 1'b0; prev_head = 1'b0; hi_len = 0; cyc = 0; last_rise = 0;
        forever begin
            @(negedge clk);
            cyc++;
            pd = sel ? 1 : 2;
            if (!mon_en) begin
                prev_pc = 1'b0;
                hi_len  = 0;
            end else begin
                if (w_pc && !prev_pc) begin
                    chk("sb_nonempty", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
                    e_bit = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
                    chk("head_bit", w_head, e_bit);
                    chk("head_stable_rise", w_head, prev_head);
                    if ((edges % 8) != 0) chk("bit_period", cyc - last_rise, 2 * pd);
                    last_rise = cyc;
                    edges++;
                end
                if (!w_pc && prev_pc) chk("high_len", hi_len, pd);
                hi_len  = w_pc ? hi_len + 1 : 0;
                prev_pc = w_pc;
            end
            prev_head = w_head;
        end
    endtask

    task automatic pulse_start(input logic v);
        verify_in = v;
        if (sel) start12 = 1'b1; else start16 = 1'b1;
        @(negedge clk);
        start12 = 1'b0;
        start16 = 1'b0;
    endtask

    // Offer a byte, queue its expected bits, wait for the handshake.
    task automatic send_byte(input logic [7:0] b);
        int n, cl;
        cl = sel ? 12 : 16;
        for (int i = 7; i >= 0; i--) begin
            if (pushed < cl) begin
                exp_q.push_back(b[i]);
                pushed++;
            end
        end
        byte_data  = b;
        byte_valid = 1'b1;
        n = 0;
        while (!w_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("byte_ready_seen", w_ready, 1'b1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic run_pass(input logic v, input logic [7:0] b0, input logic [7:0] b1,
                            input int stall, input bit third, input logic exp_err);
        int n, cl, ready_seen;
        logic pc_seen, busy_drop;
        cl = sel ? 12 : 16;
        pushed = 0;
        edges  = 0;
        pulse_start(v);
        chk("busy_after_start", w_busy, 1'b1);
        chk("error_cleared", w_err, 1'b0);
        chk("fpga_rst_on_start", w_frst, 1'b1);
        send_byte(b0);
        if (stall > 0) begin
            n = 0;
            while (!w_ready && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("stall_ready", w_ready, 1'b1);
            pc_seen = 1'b0;
            busy_drop = 1'b0;
            for (int i = 0; i < stall; i++) begin
                // Start pulses (asking for a verify pass) must be ignored.
                if (i == 10 || i == 30) begin
                    verify_in = 1'b1;
                    start16 = ~sel;
                    start12 = sel;
                end else begin
                    start16 = 1'b0;
                    start12 = 1'b0;
                end
                @(negedge clk);
                if (w_pc) pc_seen = 1'b1;
                if (!w_busy) busy_drop = 1'b1;
            end
            start16 = 1'b0;
            start12 = 1'b0;
            chk("stall_prog_clk_low", pc_seen, 1'b0);
            chk("stall_busy_held", busy_drop, 1'b0);
            chk("stall_bit_cnt", w_cnt, 8);
        end
        send_byte(b1);
        if (third) begin
            byte_data  = 8'hAA;
            byte_valid = 1'b1;
        end
        n = 0;
        ready_seen = 0;
        while (!w_done && n < 400) begin
            @(negedge clk);
            n++;
            if (w_ready) ready_seen++;
        end
        byte_valid = 1'b0;
        chk("done_seen", w_done, 1'b1);
        if (third) chk("no_third_byte_ready", ready_seen, 0);
        chk("prog_clk_edges", edges, cl);
        chk("sb_empty", exp_q.size(), 0);
        chk("bit_cnt_final", w_cnt, cl);
        chk("error_final", w_err, exp_err);
        chk("fpga_rst_final", w_frst, exp_err);
        chk("busy_at_done", w_busy, 1'b0);
        $display("pass: dut=%0d verify=%0d bytes=%h,%h stall=%0d edges=%0d bit_cnt=%0d error=%0d fpga_rst=%0d",
                 sel ? 12 : 16, v, b0, b1, stall, edges, w_cnt, w_err, w_frst);
        @(negedge clk);
        chk("done_one_cycle", w_done, 1'b0);
        chk("bit_cnt_hold", w_cnt, cl);
        chk("fpga_rst_hold", w_frst, exp_err);
    endtask

    initial begin
        int n;
        fork
            monitor();
        join_none

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_prog_clk", pc16, 1'b0);
        chk("rst_head", head16, 1'b0);
        chk("rst_ready", ready16, 1'b0);
        chk("rst_busy", busy16, 1'b0);
        chk("rst_done", done16, 1'b0);
        chk("rst_error", err16, 1'b0);
        chk("rst_bit_cnt", cnt16, 0);
        chk("rst_fpga_rst", frst16, 1'b1);
        chk("rst12_fpga_rst", frst12, 1'b1);
        chk("rst12_busy", busy12, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Load, clean verify, failing verify, stalled load with ignored starts
        run_pass(1'b0, 8'hA5, 8'h3C, 0, 1'b0, 1'b0);
        run_pass(1'b1, 8'hA5, 8'h3C, 0, 1'b0, 1'b0);
        run_pass(1'b1, 8'hA5, 8'h3D, 0, 1'b0, 1'b1);
        run_pass(1'b0, 8'hA5, 8'h3C, 50, 1'b0, 1'b0);

        // Reset in the middle of a bit while prog_clk is high
        pushed = 0;
        edges  = 0;
        pulse_start(1'b0);
        send_byte(8'hA5);
        n = 0;
        while (!pc16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_prog_clk_high", pc16, 1'b1);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("t5_prog_clk", pc16, 1'b0);
        chk("t5_fpga_rst", frst16, 1'b1);
        chk("t5_busy", busy16, 1'b0);
        chk("t5_bit_cnt", cnt16, 0);
        $display("reset: mid-bit abort prog_clk=%0d fpga_rst=%0d busy=%0d", pc16, frst16, busy16);
        @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        run_pass(1'b0, 8'hA5, 8'h3C, 0, 1'b0, 1'b0);

        // Short chain (12 bits) with PROG_DIV=1; a third byte is offered
        sel = 1'b1;
        @(negedge clk);
        run_pass(1'b0, 8'hFF, 8'hF0, 0, 1'b1, 1'b0);
        run_pass(1'b1, 8'hFF, 8'hF0, 0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
